append_fcs: RTL and testbench

Transmit-path stage that sits directly upstream of the preamble/SFD inserter. Takes a byte-wide AXI-Stream Ethernet frame (destination MAC through payload, no FCS), zero-pads it to the minimum frame length, and appends the 4-byte IEEE 802.3 CRC-32 FCS. Output is a byte stream with `tlast` on the final FCS byte, ready for preamble insertion and MII transmit.

---
 rtl/eth_pkg.sv | 17 +
 rtl/crc32_byte.sv | 20 ++
 rtl/append_fcs.sv | 118 +++++++++++
 tb/tb_append_fcs.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants and types for the TX/RX framing stages.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  // Raw register value after running the CRC over a frame plus its own FCS.
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam int ETH_MIN_FRAME_LENGTH = 60;

  typedef enum logic [1:0] {
    S_DATA,
    S_PAD,
    S_FCS
  } fcs_state_t;

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte step of the reflected CRC-32 (LSB of data first).
module crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/append_fcs.sv
// TX framing stage: pads a byte-wide frame to the minimum length and appends
// the CRC-32 FCS, least significant byte first, with tlast on the final byte.
module append_fcs
  import eth_pkg::*;
#(
  parameter int MIN_FRAME_LENGTH = ETH_MIN_FRAME_LENGTH
) (
  input  logic       clock,
  input  logic       aresetn,
  input  logic [7:0] saxis_tdata,
  input  logic       saxis_tvalid,
  output logic       saxis_tready,
  input  logic       saxis_tlast,
  output logic [7:0] maxis_tdata,
  output logic       maxis_tvalid,
  input  logic       maxis_tready,
  output logic       maxis_tlast
);

  localparam int CW = (MIN_FRAME_LENGTH > 0) ? $clog2(MIN_FRAME_LENGTH + 1) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(MIN_FRAME_LENGTH);

  fcs_state_t    state_reg, state_next;
  logic [31:0]   crc_reg, crc_next, crc_upd, fcs;
  logic [CW-1:0] count_reg, count_next, count_inc;
  logic [1:0]    index_reg, index_next;
  logic [7:0]    tdata_next, crc_in;
  logic          tvalid_next, tlast_next;
  logic          load_ok, reach_min;

  assign load_ok = !maxis_tvalid || maxis_tready;

  // Counter saturates, so any frame length is legal without wrap-around.
  assign count_inc = (count_reg == COUNT_MAX) ? count_reg : count_reg + CW'(1);
  assign reach_min = (count_inc == COUNT_MAX);

  // Pad bytes are zeros; only S_DATA feeds real input into the CRC.
  assign crc_in = (state_reg == S_DATA) ? saxis_tdata : 8'h00;
  assign fcs    = ~crc_reg;

  crc32_byte u_crc (
    .crc      (crc_reg),
    .data     (crc_in),
    .crc_next (crc_upd)
  );

  always_comb begin
    state_next   = state_reg;
    crc_next     = crc_reg;
    count_next   = count_reg;
    index_next   = index_reg;
    tdata_next   = maxis_tdata;
    tvalid_next  = maxis_tvalid && !maxis_tready;
    tlast_next   = maxis_tlast;
    saxis_tready = 1'b0;
    case (state_reg)
      S_DATA: begin
        saxis_tready = load_ok;
        if (load_ok && saxis_tvalid) begin
          tdata_next  = saxis_tdata;
          tvalid_next = 1'b1;
          tlast_next  = 1'b0;
          crc_next    = crc_upd;
          count_next  = count_inc;
          if (saxis_tlast) state_next = reach_min ? S_FCS : S_PAD;
        end
      end
      S_PAD: begin
        if (load_ok) begin
          tdata_next  = 8'h00;
          tvalid_next = 1'b1;
          tlast_next  = 1'b0;
          crc_next    = crc_upd;
          count_next  = count_inc;
          if (reach_min) state_next = S_FCS;
        end
      end
      S_FCS: begin
        // The last FCS byte leaving ends the frame; that cycle stays idle.
        if (maxis_tvalid && maxis_tlast && maxis_tready) begin
          tvalid_next = 1'b0;
          tlast_next  = 1'b0;
          state_next  = S_DATA;
          crc_next    = CRC32_INIT;
          count_next  = '0;
          index_next  = '0;
        end else if (load_ok) begin
          tdata_next  = fcs[{index_reg, 3'b000} +: 8];
          tvalid_next = 1'b1;
          tlast_next  = (index_reg == 2'd3);
          index_next  = index_reg + 2'd1;
        end
      end
      default: state_next = S_DATA;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!aresetn) begin
      state_reg    <= S_DATA;
      crc_reg      <= CRC32_INIT;
      count_reg    <= '0;
      index_reg    <= '0;
      maxis_tdata  <= 8'h00;
      maxis_tvalid <= 1'b0;
      maxis_tlast  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      crc_reg      <= crc_next;
      count_reg    <= count_next;
      index_reg    <= index_next;
      maxis_tdata  <= tdata_next;
      maxis_tvalid <= tvalid_next;
      maxis_tlast  <= tlast_next;
    end
  end

endmodule

// File: tb/tb_append_fcs.sv
// Directed and randomised checks of append_fcs with padding disabled and default.
module tb_append_fcs;

  logic       clock = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] saxis_tdata = 8'h00;
  logic       saxis_tvalid = 1'b0;
  logic       saxis_tready;
  logic       saxis_tlast = 1'b0;
  logic [7:0] maxis_tdata;
  logic       maxis_tvalid;
  logic       maxis_tready = 1'b1;
  logic       maxis_tlast;

  logic [7:0] s0_tdata = 8'h00;
  logic       s0_tvalid = 1'b0;
  logic       s0_tready;
  logic       s0_tlast = 1'b0;
  logic [7:0] m0_tdata;
  logic       m0_tvalid;
  logic       m0_tready = 1'b1;
  logic       m0_tlast;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;

  logic [7:0] out_q[$];
  logic       last_q[$];
  int         cyc_q[$];
  logic [7:0] o0_q[$];
  logic       l0_q[$];
  int         c0_q[$];

  append_fcs dut (
    .clock(clock), .aresetn(aresetn),
    .saxis_tdata(saxis_tdata), .saxis_tvalid(saxis_tvalid),
    .saxis_tready(saxis_tready), .saxis_tlast(saxis_tlast),
    .maxis_tdata(maxis_tdata), .maxis_tvalid(maxis_tvalid),
    .maxis_tready(maxis_tready), .maxis_tlast(maxis_tlast)
  );

  append_fcs #(.MIN_FRAME_LENGTH(0)) dut0 (
    .clock(clock), .aresetn(aresetn),
    .saxis_tdata(s0_tdata), .saxis_tvalid(s0_tvalid),
    .saxis_tready(s0_tready), .saxis_tlast(s0_tlast),
    .maxis_tdata(m0_tdata), .maxis_tvalid(m0_tvalid),
    .maxis_tready(m0_tready), .maxis_tlast(m0_tlast)
  );

  always #5 clock = ~clock;

  initial begin
    forever begin
      @(posedge clock);
      #1;
      maxis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: a transfer seen valid&ready at the negedge completes at the next posedge.
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (maxis_tvalid && maxis_tready) begin
      out_q.push_back(maxis_tdata);
      last_q.push_back(maxis_tlast);
      cyc_q.push_back(cyc);
    end
    if (m0_tvalid && m0_tready) begin
      o0_q.push_back(m0_tdata);
      l0_q.push_back(m0_tlast);
      c0_q.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic send_frame(input logic [7:0] d[$], input int gap, input int abort_at);
    int i;
    int guard;
    logic hs;
    i = 0;
    guard = 0;
    while (i < d.size() && !(abort_at > 0 && i == abort_at) && guard < 20000) begin
      if (gap > 0 && $urandom_range(0, 99) < gap) begin
        saxis_tvalid = 1'b0;
      end else begin
        saxis_tvalid = 1'b1;
        saxis_tdata  = d[i];
        saxis_tlast  = (i == d.size() - 1);
      end
      @(negedge clock);
      hs = saxis_tvalid && saxis_tready;
      @(posedge clock);
      #1;
      if (hs) i++;
      guard++;
    end
    saxis_tvalid = 1'b0;
    saxis_tlast  = 1'b0;
    check("send_timeout", 32'(guard < 20000), 1);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d[$],
                              output int first_cyc, output int last_cyc);
    logic [7:0] e[$];
    logic [31:0] c;
    int guard, bad, lastbad;
    e = d;
    while (e.size() < 60) e.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (e[i]) c = crc_step(c, e[i]);
    c = ~c;
    for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
    guard = 0;
    while (out_q.size() < e.size() && guard < 5000) begin
      @(posedge clock);
      guard++;
    end
    first_cyc = 0;
    last_cyc = 0;
    check({tag, "_len"}, 32'(out_q.size() >= e.size()), 1);
    if (out_q.size() < e.size()) return;
    bad = 0;
    lastbad = 0;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < e.size(); i++) begin
      if (out_q[i] !== e[i]) bad++;
      if (last_q[i] !== (i == e.size() - 1)) lastbad++;
      c = crc_step(c, out_q[i]);
    end
    check({tag, "_bytes_bad"}, bad, 0);
    check({tag, "_tlast_bad"}, lastbad, 0);
    check({tag, "_residue"}, c, 32'hDEBB20E3);
    first_cyc = cyc_q[0];
    last_cyc  = cyc_q[e.size() - 1];
    for (int i = 0; i < e.size(); i++) begin
      void'(out_q.pop_front());
      void'(last_q.pop_front());
      void'(cyc_q.pop_front());
    end
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] g[$];
    logic [7:0] exp0[13];
    int fa, la, fb, lb;
    exp0 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};

    repeat (3) @(posedge clock);
    #1;
    aresetn = 1'b1;
    check("rst_tvalid", 32'(maxis_tvalid), 0);
    check("rst_tdata", 32'(maxis_tdata), 0);
    check("rst_tlast", 32'(maxis_tlast), 0);
    check("rst_sready", 32'(saxis_tready), 1);

    // Padding disabled: standard "123456789" check vector.
    for (int i = 0; i < 9; i++) begin
      s0_tvalid = 1'b1;
      s0_tdata  = exp0[i];
      s0_tlast  = (i == 8);
      @(posedge clock);
      #1;
    end
    s0_tvalid = 1'b0;
    s0_tlast  = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    check("min0_count", o0_q.size(), 13);
    if (o0_q.size() == 13) begin
      for (int i = 0; i < 13; i++) begin
        check($sformatf("min0_byte%0d", i), 32'(o0_q[i]), 32'(exp0[i]));
        check($sformatf("min0_last%0d", i), 32'(l0_q[i]), 32'(i == 12));
      end
      check("min0_span", c0_q[12] - c0_q[0], 12);
    end

    f = '{8'hAA};
    send_frame(f, 0, 0);
    expect_frame("one_byte", f, fa, la);
    check("one_byte_span", la - fa, 63);

    f = {};
    for (int i = 0; i < 60; i++) f.push_back(8'(i * 7 + 3));
    send_frame(f, 0, 0);
    expect_frame("len60", f, fa, la);
    check("len60_span", la - fa, 63);

    f.push_back(8'h5A);
    send_frame(f, 0, 0);
    expect_frame("len61", f, fa, la);
    check("len61_span", la - fa, 64);

    // Back-to-back frames with tvalid held: exactly one idle cycle between them.
    f = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    g = '{8'hF0, 8'hE1, 8'hD2};
    send_frame(f, 0, 0);
    send_frame(g, 0, 0);
    expect_frame("b2b_a", f, fa, la);
    expect_frame("b2b_b", g, fb, lb);
    check("b2b_gap", fb - la, 2);

    // Reset mid-payload of a 100-byte frame.
    f = {};
    for (int i = 0; i < 100; i++) f.push_back(8'($urandom));
    send_frame(f, 0, 40);
    aresetn = 1'b0;
    @(posedge clock);
    #1;
    aresetn = 1'b1;
    check("midrst_tvalid", 32'(maxis_tvalid), 0);
    check("midrst_tdata", 32'(maxis_tdata), 0);
    check("midrst_tlast", 32'(maxis_tlast), 0);
    out_q = {};
    last_q = {};
    cyc_q = {};
    f = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0};
    send_frame(f, 0, 0);
    expect_frame("after_rst", f, fa, la);

    rand_rdy = 1'b1;
    for (int n = 0; n < 100; n++) begin
      f = {};
      for (int i = 0, len = $urandom_range(1, 100); i < len; i++) f.push_back(8'($urandom));
      send_frame(f, 30, 0);
      expect_frame($sformatf("rand%0d", n), f, fa, la);
    end
    rand_rdy = 1'b0;
    repeat (10) @(posedge clock);
    check("trailing_bytes", out_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
